vu_vmu_dmem_arb: RTL and testbench
==================================

# vu_vmu_dmem_arb

Two-requester arbiter that shares a single data-cache request port between the vector memory controller (requester 0) and the microthread memory controller (requester 1) of the vector memory unit. It applies round-robin arbitration with per-requester outstanding-request credits, and extends each request tag with a requester ID. Responses are routed back through one register stage.

## Interface

Parameters:
- ADDR_W, 30, request address width (word address).
- DATA_W, 64, store/load data width; wmask is DATA_W/8 bits.
- TAG_W, 11, requester-side tag width; memory-side tag is TAG_W+1.
- MAX_OUT, 8, maximum outstanding loads per requester (1..15).
- BURST, 4, maximum consecutive grants under lock (only with VMU_ARB_LOCK_EN).

Ports:
- clk, input, 1, clock, all state on rising edge.
- reset, input, 1, asynchronous active-high reset.
- req0_val / req0_rdy, in/out, 1, requester 0 handshake.
- req0_addr, req0_op, req0_data, req0_wmask, req0_tag, input, ADDR_W / 4 / DATA_W / DATA_W/8 / TAG_W, requester 0 request fields.
- req1_*, same set as req0_*, requester 1.
- mem_req_val / mem_req_rdy, out/in, 1, cache request handshake.
- mem_req_addr, mem_req_op, mem_req_data, mem_req_wmask, output, as above, muxed fields.
- mem_req_tag, output, TAG_W+1, {grant ID, requester tag}.
- mem_resp_val, input, 1; mem_resp_tag, input, TAG_W+1; mem_resp_data, input, DATA_W.
- resp0_val / resp1_val, output, 1, registered response valid per requester.
- resp_tag, output, TAG_W; resp_data, output, DATA_W; shared registered response fields.
- idle, output, 1, both outstanding counts zero and no response in flight.
- err, output, 1, sticky flag for a response to a requester with zero outstanding loads.

## Operation

- A requester is eligible when req_val=1 and it is not credit-blocked. It is credit-blocked only when req_op is a load and its outstanding count equals MAX_OUT. Stores never consume credits.
- Priority register prio (0/1), reset 0:
  - Both requesters eligible: grant = prio.
  - One eligible: grant it.
  - None eligible: mem_req_val=0.
- mem_req_val = any eligible. Fields are muxed combinationally from the granted requester. reqN_rdy = mem_req_rdy & (grant==N) & eligibleN.
- On accept (mem_req_val & mem_req_rdy), prio takes the value of the non-granted requester.
- Outstanding counters out0/out1, width 4, reset 0:
  - Increment on an accepted load from that requester.
  - Decrement on a mem_resp_val whose tag MSB selects that requester.
  - Simultaneous increment and decrement: counter unchanged.
  - Decrement at 0: counter stays 0 and err is set. The response is still forwarded.
- Response stage:
  - resp_tag and resp_data load from mem_resp_tag[TAG_W-1:0] and mem_resp_data when mem_resp_val=1.
  - resp0_val = registered (mem_resp_val & MSB==0); resp1_val = registered (mem_resp_val & MSB==1).
  - Requesters cannot stall responses.
- idle = (out0==0) & (out1==0) & ~resp0_val & ~resp1_val.
- Reset state (asynchronous): prio=0, out0=out1=0, resp0_val=resp1_val=0, resp_tag=0, resp_data=0, err=0, idle=1. Lock state (if compiled) is cleared.
- Reset asserted mid-operation discards all credits and any in-flight response. Responses arriving after reset deassertion for pre-reset requests set err.

## Timing

- Request path: zero latency, purely combinational from reqN to mem_req and from mem_req_rdy to reqN_rdy.
- Response path: exactly 1 cycle from mem_resp_val to respN_val.
- A credit freed by a response in cycle t allows a load accept in cycle t+1, not in cycle t.
- mem_req_val is never withdrawn by the arbiter while the granted requester holds val and stays eligible. prio changes only on accept.

## Configuration

- VMU_ARB_LOCK_EN defined:
  - After a grant to requester N, N keeps priority for up to BURST consecutive accepts while it remains eligible.
  - A 2-bit-plus burst counter resets to 0 on a requester switch.
  - prio flips when the count reaches BURST or N drops eligibility.
- VMU_ARB_LOCK_EN undefined: strict alternation on every accept as described in Operation. No burst counter is present.

## Test plan

- Both requesters hold loads with mem_req_rdy=1 for 4 cycles → grants 0,1,0,1; mem_req_tag MSB alternates; out0=out1=2. With VMU_ARB_LOCK_EN and BURST=4 → grants 0,0,0,0.
- Requester 0 issues 8 loads, MAX_OUT=8, no responses → 9th load sees req0_rdy=0 while a requester-1 store is accepted in the same cycle.
- Response tag {1,11'h05A} with data 64'hDEAD_BEEF in cycle t → resp1_val=1, resp_tag=11'h05A, resp_data=64'hDEAD_BEEF in cycle t+1; resp0_val=0.
- Simultaneous accepted load and response for requester 0 with out0=3 → out0 remains 3.
- Response with MSB=0 while out0=0 → err=1 and stays 1 until reset; out0 stays 0; resp0_val still pulses.
- reset asserted with out0=5 and resp1_val=1 → out0=0, resp1_val=0, idle=1 immediately (asynchronous, without waiting for a clock edge).

Source files
------------

// File: rtl/vu_vmu_dmem_arb.sv
// vu_vmu_dmem_arb
//   Shares one data-cache request port between the vector memory controller
//   (requester 0) and the microthread memory controller (requester 1).
//   Round-robin arbitration with per-requester outstanding-load credits.
//   The memory-side tag is {grant id, requester tag}. Responses are routed
//   back to the requesters through one register stage.
//
//   Optional feature: define VMU_ARB_LOCK_EN so that a granted requester
//   keeps priority for up to BURST consecutive accepts.
//
//   An op code of 4'h0 is a load and consumes a credit. Every other op code
//   is treated as a store and is never credit-blocked.
//
// Ports
//   clk, reset                      clock, asynchronous active-high reset
//   req{0,1}_val/rdy                requester handshakes
//   req{0,1}_addr/op/data/wmask/tag requester request fields
//   mem_req_val/rdy                 cache request handshake
//   mem_req_addr/op/data/wmask/tag  muxed request fields (tag has grant id as MSB)
//   mem_resp_val/tag/data           cache response
//   resp{0,1}_val, resp_tag/data    registered responses to the requesters
//   idle                            no outstanding loads and no response in flight
//   err                             sticky: response seen with zero outstanding loads
module vu_vmu_dmem_arb #(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 64,
  parameter int TAG_W   = 11,
  parameter int MAX_OUT = 8,
  parameter int BURST   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0_val,
  output logic                req0_rdy,
  input  logic [ADDR_W-1:0]   req0_addr,
  input  logic [3:0]          req0_op,
  input  logic [DATA_W-1:0]   req0_data,
  input  logic [DATA_W/8-1:0] req0_wmask,
  input  logic [TAG_W-1:0]    req0_tag,
  input  logic                req1_val,
  output logic                req1_rdy,
  input  logic [ADDR_W-1:0]   req1_addr,
  input  logic [3:0]          req1_op,
  input  logic [DATA_W-1:0]   req1_data,
  input  logic [DATA_W/8-1:0] req1_wmask,
  input  logic [TAG_W-1:0]    req1_tag,
  output logic                mem_req_val,
  input  logic                mem_req_rdy,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [3:0]          mem_req_op,
  output logic [DATA_W-1:0]   mem_req_data,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  output logic [TAG_W:0]      mem_req_tag,
  input  logic                mem_resp_val,
  input  logic [TAG_W:0]      mem_resp_tag,
  input  logic [DATA_W-1:0]   mem_resp_data,
  output logic                resp0_val,
  output logic                resp1_val,
  output logic [TAG_W-1:0]    resp_tag,
  output logic [DATA_W-1:0]   resp_data,
  output logic                idle,
  output logic                err
);

  localparam logic [3:0] OP_LOAD = 4'h0;
  localparam logic [3:0] CNT_MAX = 4'(MAX_OUT);

  logic       prio, prio_nxt;
  logic [3:0] out0, out1, out0_nxt, out1_nxt;
  logic       elig0, elig1, grant, accept;
  logic       inc0, inc1, dec0, dec1, err_set;

  // Eligibility uses the registered counts, so a credit returned by a
  // response only becomes usable on the following cycle.
  always_comb begin
    elig0 = req0_val & ~((req0_op == OP_LOAD) & (out0 == CNT_MAX));
    elig1 = req1_val & ~((req1_op == OP_LOAD) & (out1 == CNT_MAX));
    grant = (elig0 & elig1) ? prio : elig1;

    mem_req_val   = elig0 | elig1;
    mem_req_addr  = grant ? req1_addr  : req0_addr;
    mem_req_op    = grant ? req1_op    : req0_op;
    mem_req_data  = grant ? req1_data  : req0_data;
    mem_req_wmask = grant ? req1_wmask : req0_wmask;
    mem_req_tag   = grant ? {1'b1, req1_tag} : {1'b0, req0_tag};

    req0_rdy = mem_req_rdy & ~grant & elig0;
    req1_rdy = mem_req_rdy &  grant & elig1;
    accept   = mem_req_val & mem_req_rdy;
  end

  always_comb begin
    inc0 = accept & ~grant & (req0_op == OP_LOAD);
    inc1 = accept &  grant & (req1_op == OP_LOAD);
    dec0 = mem_resp_val & ~mem_resp_tag[TAG_W];
    dec1 = mem_resp_val &  mem_resp_tag[TAG_W];

    out0_nxt = out0;
    if (inc0 & ~dec0)                     out0_nxt = out0 + 4'd1;
    else if (dec0 & ~inc0 & (out0 != '0)) out0_nxt = out0 - 4'd1;

    out1_nxt = out1;
    if (inc1 & ~dec1)                     out1_nxt = out1 + 4'd1;
    else if (dec1 & ~inc1 & (out1 != '0)) out1_nxt = out1 - 4'd1;

    err_set = (dec0 & (out0 == '0)) | (dec1 & (out1 == '0));
  end

`ifdef VMU_ARB_LOCK_EN
  localparam int BCNT_W = (BURST < 4) ? 2 : $clog2(BURST + 1);

  logic [BCNT_W-1:0] bcnt, bcnt_nxt;

  // bcnt counts consecutive accepts of the requester holding priority. A
  // grant to the other requester (holder not eligible) moves the lock to it.
  always_comb begin
    prio_nxt = prio;
    bcnt_nxt = bcnt;
    if (accept) begin
      if (grant == prio) bcnt_nxt = bcnt + BCNT_W'(1);
      else               bcnt_nxt = BCNT_W'(1);
      if (bcnt_nxt >= BCNT_W'(BURST)) begin
        prio_nxt = ~grant;
        bcnt_nxt = '0;
      end else begin
        prio_nxt = grant;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) bcnt <= '0;
    else       bcnt <= bcnt_nxt;
  end
`else
  always_comb begin
    prio_nxt = prio;
    if (accept) prio_nxt = ~grant;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio      <= 1'b0;
      out0      <= '0;
      out1      <= '0;
      err       <= 1'b0;
      resp0_val <= 1'b0;
      resp1_val <= 1'b0;
      resp_tag  <= '0;
      resp_data <= '0;
    end else begin
      prio      <= prio_nxt;
      out0      <= out0_nxt;
      out1      <= out1_nxt;
      err       <= err | err_set;
      resp0_val <= mem_resp_val & ~mem_resp_tag[TAG_W];
      resp1_val <= mem_resp_val &  mem_resp_tag[TAG_W];
      if (mem_resp_val) begin
        resp_tag  <= mem_resp_tag[TAG_W-1:0];
        resp_data <= mem_resp_data;
      end
    end
  end

  assign idle = (out0 == '0) & (out1 == '0) & ~resp0_val & ~resp1_val;

endmodule

// File: tb/tb_vu_vmu_dmem_arb.sv
// Self-checking bench for vu_vmu_dmem_arb (default build, lock disabled).
module tb_vu_vmu_dmem_arb;
  localparam int ADDR_W  = 30;
  localparam int DATA_W  = 64;
  localparam int TAG_W   = 11;
  localparam int MAX_OUT = 8;

  logic clk = 1'b0;
  logic reset;
  logic req0_val, req0_rdy, req1_val, req1_rdy;
  logic [ADDR_W-1:0]   req0_addr, req1_addr, mem_req_addr;
  logic [3:0]          req0_op, req1_op, mem_req_op;
  logic [DATA_W-1:0]   req0_data, req1_data, mem_req_data, mem_resp_data, resp_data;
  logic [DATA_W/8-1:0] req0_wmask, req1_wmask, mem_req_wmask;
  logic [TAG_W-1:0]    req0_tag, req1_tag, resp_tag;
  logic                mem_req_val, mem_req_rdy, mem_resp_val;
  logic [TAG_W:0]      mem_req_tag, mem_resp_tag;
  logic                resp0_val, resp1_val, idle, err;

  int total = 0;
  int bad   = 0;

  vu_vmu_dmem_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W),
                    .MAX_OUT(MAX_OUT), .BURST(4)) dut (
    .clk(clk), .reset(reset),
    .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_addr(req0_addr),
    .req0_op(req0_op), .req0_data(req0_data), .req0_wmask(req0_wmask),
    .req0_tag(req0_tag),
    .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_addr(req1_addr),
    .req1_op(req1_op), .req1_data(req1_data), .req1_wmask(req1_wmask),
    .req1_tag(req1_tag),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy),
    .mem_req_addr(mem_req_addr), .mem_req_op(mem_req_op),
    .mem_req_data(mem_req_data), .mem_req_wmask(mem_req_wmask),
    .mem_req_tag(mem_req_tag),
    .mem_resp_val(mem_resp_val), .mem_resp_tag(mem_resp_tag),
    .mem_resp_data(mem_resp_data),
    .resp0_val(resp0_val), .resp1_val(resp1_val), .resp_tag(resp_tag),
    .resp_data(resp_data), .idle(idle), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: credit counts, priority owner, sticky error and the
  // response that will be visible after the next edge.
  int              mcnt[2];
  int              mprio;
  bit              merr, mr0, mr1;
  logic [TAG_W-1:0]  mrtag;
  logic [DATA_W-1:0] mrdata;

  always @(negedge clk) begin
    bit v[2], e[2], dec[2], inc[2], ev, acc;
    logic [3:0] op[2];
    int g, m;
    logic [ADDR_W-1:0] a[2];
    logic [DATA_W-1:0] d[2];
    logic [DATA_W/8-1:0] w[2];
    logic [TAG_W-1:0] t[2];

    if (reset) begin
      mcnt[0] = 0; mcnt[1] = 0; mprio = 0; merr = 0;
      mr0 = 0; mr1 = 0; mrtag = '0; mrdata = '0;
    end

    v[0] = req0_val; v[1] = req1_val;
    op[0] = req0_op; op[1] = req1_op;
    a[0] = req0_addr; a[1] = req1_addr;
    d[0] = req0_data; d[1] = req1_data;
    w[0] = req0_wmask; w[1] = req1_wmask;
    t[0] = req0_tag; t[1] = req1_tag;
    for (int i = 0; i < 2; i++)
      e[i] = v[i] && !(op[i] == 4'h0 && mcnt[i] == MAX_OUT);
    if (e[0] && e[1]) g = mprio;
    else if (e[0])    g = 0;
    else              g = 1;
    ev = e[0] || e[1];

    chk("mem_req_val", 64'(mem_req_val), 64'(ev));
    if (ev) begin
      chk("mem_req_addr",  64'(mem_req_addr),  64'(a[g]));
      chk("mem_req_op",    64'(mem_req_op),    64'(op[g]));
      chk("mem_req_data",  64'(mem_req_data),  64'(d[g]));
      chk("mem_req_wmask", 64'(mem_req_wmask), 64'(w[g]));
      chk("mem_req_tag",   64'(mem_req_tag),   64'({g[0], t[g]}));
    end
    chk("req0_rdy", 64'(req0_rdy), 64'(mem_req_rdy && ev && g == 0 && e[0]));
    chk("req1_rdy", 64'(req1_rdy), 64'(mem_req_rdy && ev && g == 1 && e[1]));
    chk("resp0_val", 64'(resp0_val), 64'(mr0));
    chk("resp1_val", 64'(resp1_val), 64'(mr1));
    if (mr0 || mr1) begin
      chk("resp_tag",  64'(resp_tag),  64'(mrtag));
      chk("resp_data", 64'(resp_data), 64'(mrdata));
    end
    chk("idle", 64'(idle), 64'(mcnt[0] == 0 && mcnt[1] == 0 && !mr0 && !mr1));
    chk("err", 64'(err), 64'(merr));
    chk("out0", 64'(dut.out0), 64'(mcnt[0]));
    chk("out1", 64'(dut.out1), 64'(mcnt[1]));

    if (!reset) begin
      acc = ev && mem_req_rdy;
      m = int'(mem_resp_tag[TAG_W]);
      for (int i = 0; i < 2; i++) begin
        inc[i] = acc && g == i && op[i] == 4'h0;
        dec[i] = mem_resp_val && m == i;
        if (dec[i] && mcnt[i] == 0) merr = 1;
        if (inc[i] && !dec[i]) mcnt[i]++;
        else if (dec[i] && !inc[i] && mcnt[i] > 0) mcnt[i]--;
      end
      if (acc) mprio = 1 - g;
      mr0 = mem_resp_val && m == 0;
      mr1 = mem_resp_val && m == 1;
      if (mem_resp_val) begin
        mrtag  = mem_resp_tag[TAG_W-1:0];
        mrdata = mem_resp_data;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic resp(input bit msb, input logic [TAG_W-1:0] tg, input logic [DATA_W-1:0] dt);
    mem_resp_val = 1'b1; mem_resp_tag = {msb, tg}; mem_resp_data = dt;
    tick();
    mem_resp_val = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req0_val = 0; req1_val = 0; mem_req_rdy = 0; mem_resp_val = 0;
    mem_resp_tag = '0; mem_resp_data = '0;
    req0_addr = 30'h0100_00A0; req0_op = 4'h0; req0_data = 64'h0123_4567_89AB_CDEF;
    req0_wmask = 8'hF0; req0_tag = 11'h111;
    req1_addr = 30'h2AAA_AAAA; req1_op = 4'h0; req1_data = 64'hFEDC_BA98_7654_3210;
    req1_wmask = 8'h0F; req1_tag = 11'h222;
    repeat (2) tick();
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_resp_tag", 64'(resp_tag), 64'd0);
    reset = 1'b0;
    tick();

    // Both requesters hold loads: strict alternation 0,1,0,1.
    req0_val = 1; req1_val = 1; mem_req_rdy = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("alt_grant", 64'(mem_req_tag[TAG_W]), 64'(k % 2));
      tick();
    end
    req0_val = 0; req1_val = 0;
    chk("alt_out0", 64'(dut.out0), 64'd2);
    chk("alt_out1", 64'(dut.out1), 64'd2);

    // Routed response, one cycle later.
    resp(1'b1, 11'h05A, 64'hDEAD_BEEF);
    chk("rsp_r1", 64'(resp1_val), 64'd1);
    chk("rsp_r0", 64'(resp0_val), 64'd0);
    chk("rsp_tag", 64'(resp_tag), 64'h05A);
    chk("rsp_data", resp_data, 64'hDEAD_BEEF);
    resp(1'b1, 11'h05B, 64'h1);
    resp(1'b0, 11'h001, 64'h2);
    resp(1'b0, 11'h002, 64'h3);
    tick();
    chk("drain_idle", 64'(idle), 64'd1);

    // Simultaneous accepted load and response for requester 0.
    req0_val = 1;
    repeat (3) tick();
    mem_resp_val = 1; mem_resp_tag = {1'b0, 11'h003}; mem_resp_data = 64'h4;
    tick();
    req0_val = 0; mem_resp_val = 0;
    chk("simul_out0", 64'(dut.out0), 64'd3);
    repeat (3) resp(1'b0, 11'h004, 64'h5);

    // Credit exhaustion while a requester-1 store goes through.
    req0_val = 1;
    repeat (8) tick();
    chk("full_out0", 64'(dut.out0), 64'd8);
    req1_val = 1; req1_op = 4'h1;
    @(negedge clk);
    chk("full_rdy0", 64'(req0_rdy), 64'd0);
    chk("full_rdy1", 64'(req1_rdy), 64'd1);
    chk("full_grant", 64'(mem_req_tag[TAG_W]), 64'd1);
    tick();
    req0_val = 0; req1_val = 0; req1_op = 4'h0;
    chk("store_out1", 64'(dut.out1), 64'd0);
    repeat (8) resp(1'b0, 11'h005, 64'h6);
    tick();
    chk("full_idle", 64'(idle), 64'd1);

    // Response with no outstanding load.
    resp(1'b0, 11'h033, 64'h5555);
    chk("err_set", 64'(err), 64'd1);
    chk("err_r0", 64'(resp0_val), 64'd1);
    chk("err_out0", 64'(dut.out0), 64'd0);
    repeat (3) tick();
    chk("err_sticky", 64'(err), 64'd1);

    // Asynchronous reset mid-cycle with credits and a response in flight.
    req0_val = 1;
    repeat (5) tick();
    req0_val = 0;
    chk("pre_out0", 64'(dut.out0), 64'd5);
    resp(1'b1, 11'h077, 64'h7);
    chk("pre_r1", 64'(resp1_val), 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("arst_out0", 64'(dut.out0), 64'd0);
    chk("arst_r1", 64'(resp1_val), 64'd0);
    chk("arst_idle", 64'(idle), 64'd1);
    chk("arst_err", 64'(err), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    resp(1'b0, 11'h010, 64'h8);
    chk("post_rst_err", 64'(err), 64'd1);
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
